// File: rtl/stream_pkg.sv
// Shared width defaults and FSM state type for the stream demux slice.
package stream_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_QOS_WIDTH      = 4;
    localparam int DEF_STREAM_COUNT   = 2;
    localparam int DEF_DROP_CNT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } demux_state_e;

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered buffer; reloads on simultaneous push/pop for full throughput.
module stream_reg_slice #(
    parameter int DATA_WIDTH = stream_pkg::DEF_DATA_WIDTH,
    parameter int QOS_WIDTH  = stream_pkg::DEF_QOS_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [QOS_WIDTH-1:0]  s_qos,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [QOS_WIDTH-1:0]  m_qos,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    logic push;

    assign s_ready = ~m_valid | m_ready;
    assign push    = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_qos   <= '0;
            m_last  <= 1'b0;
        end else if (push) begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_qos   <= s_qos;
            m_last  <= s_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Packet-locked demux: routes a tagged stream to per-id output buffers, drops invalid ids.
//
//   state | meaning
//   IDLE  | between packets; route by live s_id_i
//   BUSY  | mid-packet; route by lock_id captured on the first beat
module stream_demux
    import stream_pkg::*;
#(
    parameter int T_DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int T_QOS__WIDTH   = DEF_QOS_WIDTH,
    parameter int STREAM_COUNT   = DEF_STREAM_COUNT,
    parameter int T_ID___WIDTH   = $clog2(STREAM_COUNT),
    parameter int DROP_CNT_WIDTH = DEF_DROP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [T_DATA_WIDTH-1:0]   s_data_i,
    input  logic [T_QOS__WIDTH-1:0]   s_qos_i,
    input  logic [T_ID___WIDTH-1:0]   s_id_i,
    input  logic                      s_last_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    output logic [T_DATA_WIDTH-1:0]   m_data_o [STREAM_COUNT-1:0],
    output logic [T_QOS__WIDTH-1:0]   m_qos_o  [STREAM_COUNT-1:0],
    output logic [STREAM_COUNT-1:0]   m_last_o,
    output logic [STREAM_COUNT-1:0]   m_valid_o,
    input  logic [STREAM_COUNT-1:0]   m_ready_i,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o
);

    demux_state_e              state, state_next;
    logic [T_ID___WIDTH-1:0]   lock_id;
    logic [T_ID___WIDTH-1:0]   target;
    logic                      target_ok;
    logic                      accept;
    logic [STREAM_COUNT-1:0]   push;
    logic [STREAM_COUNT-1:0]   slice_ready;

    // Invalid targets match no slice, so ready defaults high and beats are swallowed.
    always_comb begin
        target    = (state == IDLE) ? s_id_i : lock_id;
        target_ok = (int'(target) < STREAM_COUNT);
        s_ready_o = 1'b1;
        push      = '0;
        for (int i = 0; i < STREAM_COUNT; i++) begin
            if (int'(target) == i) begin
                s_ready_o = slice_ready[i];
                push[i]   = s_valid_i;
            end
        end
    end

    assign accept = s_valid_i & s_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (accept) begin
            state_next = s_last_i ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_id <= '0;
        end else if ((state == IDLE) && accept && !s_last_i) begin
            lock_id <= s_id_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_o <= '0;
        end else if (accept && !target_ok && s_last_i && (drop_cnt_o != '1)) begin
            drop_cnt_o <= drop_cnt_o + DROP_CNT_WIDTH'(1);
        end
    end

    for (genvar g = 0; g < STREAM_COUNT; g++) begin : g_slice
        stream_reg_slice #(
            .DATA_WIDTH (T_DATA_WIDTH),
            .QOS_WIDTH  (T_QOS__WIDTH)
        ) u_slice (
            .clk     (clk),
            .rst     (rst),
            .s_data  (s_data_i),
            .s_qos   (s_qos_i),
            .s_last  (s_last_i),
            .s_valid (push[g]),
            .s_ready (slice_ready[g]),
            .m_data  (m_data_o[g]),
            .m_qos   (m_qos_o[g]),
            .m_last  (m_last_o[g]),
            .m_valid (m_valid_o[g]),
            .m_ready (m_ready_i[g])
        );
    end

endmodule
